// File: rtl/my_pecell_reset_sequencer.sv
// Reset sequencer for the PE cell array: synchronizes rst_n deassertion, releases the
// per-domain resets one stage at a time, then counts run cycles until a soft reset restarts it.
module my_pecell_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int NUM_STAGES      = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int SOFT_RST_CYCLES = 8,
    parameter int CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic                  sync_rst_n,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  init_done,
    output logic [CNT_W-1:0]      cycle_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SOFT_W = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SOFT_W-1:0]     SOFT_LAST = SOFT_W'(SOFT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [NUM_STAGES-1:0] STAGES_IN = {NUM_STAGES{1'b0}};

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SOFT    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [SOFT_W-1:0]      soft_q, soft_d;
    logic [NUM_STAGES-1:0]  stage_q, stage_d;
    logic                   init_q, init_d;
    logic                   ack_q, ack_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  stage_next_s;

    // Reset-deassert synchronizer: async clear, shifts in ones once rst_n is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Releasing the next stage means shifting one more 1 in from the bottom.
    assign stage_next_s = NUM_STAGES'({stage_q, 1'b1});

    // Next-state and registered-output logic for the release sequencer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        soft_d  = soft_q;
        stage_d = stage_q;
        init_d  = init_q;
        ack_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SYNC: begin
                // Leave SYNC on the same edge sync_rst_n rises, so stage timing counts from it.
                if (sync_q[SYNC_STAGES-2]) begin
                    state_d = ST_RELEASE;
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_RELEASE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = {HOLD_W{1'b0}};
                    stage_d = stage_next_s;
                    if (&stage_next_s) begin
                        init_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    ack_d   = 1'b1;
                    stage_d = STAGES_IN;
                    init_d  = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    soft_d  = {SOFT_W{1'b0}};
                    state_d = ST_SOFT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SOFT: begin
                if (soft_q == SOFT_LAST) begin
                    state_d = ST_RELEASE;
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    soft_d = soft_q + SOFT_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_SYNC;
                stage_d = STAGES_IN;
                init_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            hold_q  <= {HOLD_W{1'b0}};
            soft_q  <= {SOFT_W{1'b0}};
            stage_q <= STAGES_IN;
            init_q  <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            soft_q  <= soft_d;
            stage_q <= stage_d;
            init_q  <= init_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_rst_n   = sync_q[SYNC_STAGES-1];
    assign stage_rst_n  = stage_q;
    assign init_done    = init_q;
    assign soft_rst_ack = ack_q;
    assign cycle_cnt    = cnt_q;

endmodule

// File: tb/tb_my_pecell_reset_sequencer.sv
// Bench for my_pecell_reset_sequencer: three parameterizations checked every cycle against
// a timeline model (edge numbers and release bases), plus literal timing expectations.
module tb_my_pecell_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic        ack0, ack1, ack2, sync0, sync1, sync2, init0, init1, init2;
    logic [3:0]  st0, st1;
    logic [0:0]  st2;
    logic [31:0] cnt0, cnt2;
    logic [3:0]  cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    my_pecell_reset_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(req0), .soft_rst_ack(ack0),
        .sync_rst_n(sync0), .stage_rst_n(st0), .init_done(init0), .cycle_cnt(cnt0));

    my_pecell_reset_sequencer #(.SYNC_STAGES(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(req1), .soft_rst_ack(ack1),
        .sync_rst_n(sync1), .stage_rst_n(st1), .init_done(init1), .cycle_cnt(cnt1));

    my_pecell_reset_sequencer #(.HOLD_CYCLES(1), .NUM_STAGES(1), .SOFT_RST_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(req2), .soft_rst_ack(ack2),
        .sync_rst_n(sync2), .stage_rst_n(st2), .init_done(init2), .cycle_cnt(cnt2));

    // Model: n = edges since rst_n release; base = edge at which the release phase begins.
    int p_s[3]    = '{2, 3, 2};
    int p_h[3]    = '{16, 16, 1};
    int p_n[3]    = '{4, 4, 1};
    int p_soft[3] = '{8, 8, 1};
    int p_w[3]    = '{32, 4, 32};

    longint n;
    longint base[3];
    longint soft_e[3];
    logic [2:0] reqv;
    assign reqv = {req2, req1, req0};

    function automatic longint run_edge(int i);
        return base[i] + longint'(p_h[i]) * longint'(p_n[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
            for (int i = 0; i < 3; i++) begin
                base[i]   <= longint'(p_s[i]);
                soft_e[i] <= -1;
            end
        end else begin
            n <= n + 1;
            for (int i = 0; i < 3; i++) begin
                if (reqv[i] && n >= run_edge(i)) begin
                    soft_e[i] <= n + 1;
                    base[i]   <= n + 1 + longint'(p_soft[i]);
                end
            end
        end
    end

    function automatic longint e_stage(int i);
        longint k;
        if (n < base[i]) k = 0;
        else begin
            k = (n - base[i]) / p_h[i];
            if (k > p_n[i]) k = p_n[i];
        end
        return (longint'(1) << k) - 1;
    endfunction

    function automatic longint e_cnt(int i);
        longint lim;
        longint r;
        lim = (longint'(1) << p_w[i]) - 1;
        r = run_edge(i);
        if (n < r) return 0;
        return ((n - r) > lim) ? lim : (n - r);
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    task automatic cmp_inst(int i, longint s, longint st, longint in, longint a, longint c);
        chk($sformatf("sync_rst_n[%0d]", i), s, longint'(n >= p_s[i]));
        chk($sformatf("stage_rst_n[%0d]", i), st, e_stage(i));
        chk($sformatf("init_done[%0d]", i), in, longint'(n >= run_edge(i)));
        chk($sformatf("soft_rst_ack[%0d]", i), a, longint'(n == soft_e[i]));
        chk($sformatf("cycle_cnt[%0d]", i), c, e_cnt(i));
    endtask

    task automatic cmp_all();
        cmp_inst(0, longint'(sync0), longint'(st0), longint'(init0), longint'(ack0), longint'(cnt0));
        cmp_inst(1, longint'(sync1), longint'(st1), longint'(init1), longint'(ack1), longint'(cnt1));
        cmp_inst(2, longint'(sync2), longint'(st2), longint'(init2), longint'(ack2), longint'(cnt2));
    endtask

    task automatic step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic goto_edge(int k);
        int g;
        g = 0;
        while (n < k && g < 1000) begin
            step();
            g++;
        end
        if (n < k) begin
            miscompares++;
            $display("FAIL goto_edge: reached %0d required %0d", n, k);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_st0"}, longint'(st0), 0);
        chk({tag, "_sync0"}, longint'(sync0), 0);
        chk({tag, "_init0"}, longint'(init0), 0);
        chk({tag, "_cnt1"}, longint'(cnt1), 0);
        chk({tag, "_init2"}, longint'(init2), 0);
        chk({tag, "_cnt2"}, longint'(cnt2), 0);
    endtask

    initial begin
        int hold;
        // Reset state
        repeat (3) step();
        chk_all_zero("por");
        chk("por_ack0", longint'(ack0), 0);
        #1 rst_n = 1'b1;

        // Power-on timeline with a request held 10..60 that must be ignored
        goto_edge(1);  chk("pwr_sync_e1", longint'(sync0), 0);
        goto_edge(2);  chk("pwr_sync_e2", longint'(sync0), 1);
        goto_edge(3);  chk("min_stage_e3", longint'(st2), 1);
                       chk("min_init_e3", longint'(init2), 1);
        goto_edge(9);  req0 = 1'b1;
        goto_edge(17); chk("pwr_st_e17", longint'(st0), 0);
        goto_edge(18); chk("pwr_st_e18", longint'(st0), 1);
        goto_edge(34); chk("pwr_st_e34", longint'(st0), 3);
        goto_edge(50); chk("pwr_st_e50", longint'(st0), 7);
        goto_edge(60); req0 = 1'b0;
        goto_edge(65); chk("pwr_init_e65", longint'(init0), 0);
        goto_edge(66); chk("pwr_st_e66", longint'(st0), 15);
                       chk("pwr_init_e66", longint'(init0), 1);
        goto_edge(76); chk("pwr_cnt_e76", longint'(cnt0), 10);
        goto_edge(82); chk("sat_cnt_e82", longint'(cnt1), 15);
        goto_edge(90); chk("sat_cnt_e90", longint'(cnt1), 15);

        // Soft reset in RUN sampled at edge 100
        goto_edge(99);  req0 = 1'b1;
        goto_edge(100); chk("soft_ack_e100", longint'(ack0), 1);
                        chk("soft_st_e100", longint'(st0), 0);
                        chk("soft_init_e100", longint'(init0), 0);
                        chk("soft_cnt_e100", longint'(cnt0), 0);
        req0 = 1'b0;
        goto_edge(101); chk("soft_ack_e101", longint'(ack0), 0);
        goto_edge(123); chk("soft_st_e123", longint'(st0), 0);
        goto_edge(124); chk("soft_st_e124", longint'(st0), 1);
        goto_edge(171); chk("soft_init_e171", longint'(init0), 0);
        goto_edge(172); chk("soft_init_e172", longint'(init0), 1);

        // Mid-sequence reset between edges 40 and 41
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_a");
        step();
        #1 rst_n = 1'b1;
        goto_edge(40); chk("mid_st_e40", longint'(st0), 3);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        cmp_all();
        repeat (2) step();
        #1 rst_n = 1'b1;

        // Repeated timeline, request held high through edge 67
        goto_edge(2);  chk("rep_sync_e2", longint'(sync0), 1);
        goto_edge(9);  req0 = 1'b1;
        goto_edge(18); chk("rep_st_e18", longint'(st0), 1);
        goto_edge(66); chk("held_ack_e66", longint'(ack0), 0);
                       chk("held_init_e66", longint'(init0), 1);
        goto_edge(67); chk("held_ack_e67", longint'(ack0), 1);
        goto_edge(68); chk("held_ack_e68", longint'(ack0), 0);
        goto_edge(80); chk("held_ack_e80", longint'(ack0), 0);
        req0 = 1'b0;

        // Randomized requests and occasional asynchronous resets
        for (int it = 0; it < 4000; it++) begin
            step();
            req0 = ($urandom_range(0, 15) == 0);
            req1 = ($urandom_range(0, 63) == 0);
            req2 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                #1 cmp_all();
                hold = $urandom_range(0, 3);
                for (int j = 0; j < hold; j++) step();
                #1 rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
